// File: rtl/vliw_fetch_pkg.sv
// Shared types and constants for the VLIW instruction fetch front end.
//   LANES/INST_W/BUNDLE_W : bundle geometry (4 x 32 = 128 bits)
//   PC_STEP               : byte distance between consecutive bundles
//   RESET_PC              : PC value presented after reset
//   bundle_t              : one queued bundle, its lane0 address plus data
package vliw_fetch_pkg;

  localparam int          LANES      = 4;
  localparam int          INST_W     = 32;
  localparam int          BUNDLE_W   = LANES * INST_W;
  localparam int          FIFO_DEPTH = 2;
  localparam logic [31:0] PC_STEP    = 32'd16;
  localparam logic [31:0] RESET_PC   = 32'h4;

  typedef struct packed {
    logic [31:0]         pc;
    logic [BUNDLE_W-1:0] data;
  } bundle_t;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Bus bundle for the fetch stage: PC side, instruction memory side and
// decode side.
//   master : environment (PC, instruction memory, decode)
//   slave  : the fetch unit
interface inst_fetch_unit_if;
  import vliw_fetch_pkg::*;

  // PC side
  logic [31:0]         pc_in;
  logic                squash_in;
  logic                halt_in;
  logic                stall_out;
  // instruction memory side
  logic                imem_rd_en;
  logic [31:0]         imem_addr;
  logic [BUNDLE_W-1:0] imem_rdata;
  // decode side
  logic                bundle_valid;
  logic [BUNDLE_W-1:0] bundle_data;
  logic [31:0]         bundle_pc;
  logic                bundle_ready;
  logic                halted;

  modport master (
    output pc_in, squash_in, halt_in, imem_rdata, bundle_ready,
    input  stall_out, imem_rd_en, imem_addr, bundle_valid, bundle_data,
           bundle_pc, halted
  );

  modport slave (
    input  pc_in, squash_in, halt_in, imem_rdata, bundle_ready,
    output stall_out, imem_rd_en, imem_addr, bundle_valid, bundle_data,
           bundle_pc, halted
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous bundle queue between instruction memory and decode.
//   clk, rst : clock, synchronous active-high reset
//   push/din : write one bundle
//   pop      : drop the head
//   flush    : empty the queue (wins over push/pop)
//   head     : oldest entry, meaningful while count != 0
//   count    : occupancy 0..DEPTH
module fetch_fifo
  import vliw_fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  bundle_t          din,
  output bundle_t          head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  bundle_t          mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage between the program counter and the decode lanes. Issues one
// bundle read per cycle while it holds buffer credit, queues the returned
// bundles, flushes wrong-path work on squash and drains to a clean halt.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of inst_fetch_unit_if (PC, imem, decode signals)
module inst_fetch_unit
  import vliw_fetch_pkg::*;
#(
  parameter int LANES  = vliw_fetch_pkg::LANES,
  parameter int INST_W = vliw_fetch_pkg::INST_W,
  parameter int DEPTH  = vliw_fetch_pkg::FIFO_DEPTH
) (
  input logic               clk,
  input logic               rst,
  inst_fetch_unit_if.slave  bus
);

  localparam int               CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0]   DEPTH_V = (CNT_W + 1)'(DEPTH);

  logic [CNT_W-1:0]        count;
  logic                    inflight;
  logic [31:0]             inflight_pc;
  logic                    halt_q;
  logic                    pop;
  logic                    push;
  logic                    issue;
  logic [CNT_W:0]          credit_used;
  logic [LANES*INST_W-1:0] rdata;
  bundle_t                 wr_bundle;
  bundle_t                 head;

  assign rdata = bus.imem_rdata;

  // A squash kills the head before decode may take it.
  assign pop  = bus.bundle_valid & bus.bundle_ready & ~bus.squash_in;
  assign push = inflight & ~bus.squash_in;

  // Credit counts queued entries plus the read still in flight, minus the
  // slot freed by this cycle's pop. Squash empties the queue this edge, so
  // its credit is released immediately and the target issues at once.
  assign credit_used = (bus.squash_in ? '0 : {1'b0, count})
                     + {{CNT_W{1'b0}}, inflight}
                     - {{CNT_W{1'b0}}, pop};

  assign issue = ~rst & ~halt_q & ~bus.halt_in & (credit_used < DEPTH_V);

  assign bus.imem_rd_en = issue;
  assign bus.imem_addr  = bus.pc_in;
  assign bus.stall_out  = ~issue;

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight    <= 1'b0;
      inflight_pc <= '0;
      halt_q      <= 1'b0;
    end else begin
      inflight    <= issue;
      inflight_pc <= bus.pc_in;
      if (bus.halt_in) halt_q <= 1'b1;
    end
  end

  assign wr_bundle.pc   = inflight_pc;
  assign wr_bundle.data = rdata;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.squash_in),
    .din   (wr_bundle),
    .head  (head),
    .count (count)
  );

  assign bus.bundle_valid = (count != '0);
  assign bus.bundle_pc    = head.pc;
  assign bus.bundle_data  = head.data;
  assign bus.halted       = halt_q & (count == '0) & ~inflight;

  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;
  import vliw_fetch_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_fetch_unit_if bus();

  inst_fetch_unit #(.LANES(LANES), .INST_W(INST_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: every issued PC lives in one ordered list until decode
  // takes it, a squash discards it, or reset clears it. An entry issued in
  // cycle t is visible to decode from cycle t+2.
  typedef struct {
    logic [31:0] pc;
    int          t;
  } ent_t;

  ent_t        q[$];
  int          cyc;
  bit          halt_q_m;
  logic [31:0] pc_cur;
  int          n_checks;
  int          n_fail;

  // decisions and expectations for the current cycle
  bit             c_rst, c_sq, c_halt, c_pop, c_issue;
  logic [31:0]    c_pc;
  bit             exp_valid, exp_halted, check_en;
  logic [31:0]    exp_pc;
  logic [127:0]   exp_data;

  function automatic logic [31:0] inst_at(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
  endfunction

  function automatic logic [127:0] bundle_at(input logic [31:0] a);
    return {inst_at(a + 32'd12), inst_at(a + 32'd8), inst_at(a + 32'd4), inst_at(a)};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("bundle_valid", bus.bundle_valid, exp_valid);
      if (exp_valid) begin
        chk("bundle_pc", bus.bundle_pc, exp_pc);
        chk("bundle_data", bus.bundle_data, exp_data);
      end
      chk("imem_rd_en", bus.imem_rd_en, c_issue);
      chk("stall_out", bus.stall_out, !c_issue);
      if (c_issue) chk("imem_addr", bus.imem_addr, c_pc);
      chk("halted", bus.halted, exp_halted);
    end
  end

  task automatic step(input bit r, input bit sq, input logic [31:0] tgt,
                      input bit h, input bit rdy);
    bit          prev_issue;
    logic [31:0] prev_pc;
    bit          head_vis;
    int          used;
    @(posedge clk);
    #1;
    prev_issue = c_issue;
    prev_pc    = c_pc;
    // retire the previous cycle into the model
    if (c_rst) begin
      q.delete();
      halt_q_m = 1'b0;
      pc_cur   = RESET_PC;
    end else begin
      if (c_sq) q.delete();
      else if (c_pop) void'(q.pop_front());
      if (c_issue) q.push_back('{pc: c_pc, t: cyc});
      if (c_halt) halt_q_m = 1'b1;
      pc_cur = c_issue ? c_pc + PC_STEP : c_pc;
    end
    cyc++;

    c_rst  = r;
    c_sq   = sq;
    c_halt = h;
    c_pc   = sq ? tgt : pc_cur;
    rst               = r;
    bus.squash_in     = sq;
    bus.pc_in         = c_pc;
    bus.halt_in       = h;
    bus.bundle_ready  = rdy;
    bus.imem_rdata    = prev_issue ? bundle_at(prev_pc)
                                   : {$urandom, $urandom, $urandom, $urandom};

    head_vis   = (q.size() > 0) && (q[0].t <= cyc - 2);
    exp_valid  = head_vis;
    exp_pc     = head_vis ? q[0].pc : 32'h0;
    exp_data   = head_vis ? bundle_at(q[0].pc) : 128'h0;
    c_pop      = head_vis && rdy && !sq;
    if (sq) used = ((q.size() > 0) && (q[$].t == cyc - 1)) ? 1 : 0;
    else    used = q.size() - int'(c_pop);
    c_issue    = !r && !halt_q_m && !h && (used < DEPTH);
    exp_halted = halt_q_m && (q.size() == 0);
    check_en   = 1'b1;
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, 32'h0, 0, rdy);
  endtask

  initial begin
    bit          r, sq, h, rdy, hstim;
    logic [31:0] tgt;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    check_en = 1'b0;
    halt_q_m = 1'b0;
    pc_cur   = RESET_PC;
    c_rst = 1'b1; c_sq = 1'b0; c_halt = 1'b0; c_pop = 1'b0; c_issue = 1'b0;
    c_pc  = RESET_PC;
    rst = 1'b1;
    bus.pc_in = RESET_PC; bus.squash_in = 1'b0; bus.halt_in = 1'b0;
    bus.bundle_ready = 1'b0; bus.imem_rdata = '0;
    repeat (2) @(posedge clk);

    // free run
    step(0, 0, 0, 0, 1);
    chk("free_rd_en0", bus.imem_rd_en, 1'b1);
    chk("free_addr0", bus.imem_addr, 32'h4);
    step(0, 0, 0, 0, 1);
    chk("free_addr1", bus.imem_addr, 32'h14);
    step(0, 0, 0, 0, 1);
    chk("free_pc0", bus.bundle_pc, 32'h4);
    chk("free_stall", bus.stall_out, 1'b0);
    step(0, 0, 0, 0, 1);
    chk("free_pc1", bus.bundle_pc, 32'h14);
    step(0, 0, 0, 0, 1);
    chk("free_pc2", bus.bundle_pc, 32'h24);
    step(1, 0, 0, 0, 0);

    // backpressure
    run(2, 0);
    step(0, 0, 0, 0, 0);
    chk("bp_stall", bus.stall_out, 1'b1);
    chk("bp_rd_en", bus.imem_rd_en, 1'b0);
    step(0, 0, 0, 0, 0);
    chk("bp_stall2", bus.stall_out, 1'b1);
    step(0, 0, 0, 0, 1);
    chk("bp_pc0", bus.bundle_pc, 32'h4);
    chk("bp_addr", bus.imem_addr, 32'h24);
    step(0, 0, 0, 0, 1);
    chk("bp_pc1", bus.bundle_pc, 32'h14);
    step(0, 0, 0, 0, 1);
    chk("bp_pc2", bus.bundle_pc, 32'h24);
    step(1, 0, 0, 0, 0);

    // squash with 0x14 queued, 0x24 in flight, decode ready
    run(2, 0);
    step(0, 0, 0, 0, 1);
    step(0, 1, 32'h100, 0, 1);
    chk("sq_valid_head", bus.bundle_valid, 1'b1);
    chk("sq_rd_en", bus.imem_rd_en, 1'b1);
    chk("sq_addr", bus.imem_addr, 32'h100);
    step(0, 0, 0, 0, 1);
    chk("sq_empty", bus.bundle_valid, 1'b0);
    step(0, 0, 0, 0, 1);
    chk("sq_target", bus.bundle_pc, 32'h100);
    step(0, 0, 0, 0, 1);
    chk("sq_next", bus.bundle_pc, 32'h110);
    step(1, 0, 0, 0, 0);

    // halt with two bundles queued
    run(3, 0);
    step(0, 0, 0, 1, 0);
    chk("halt_rd_en", bus.imem_rd_en, 1'b0);
    step(0, 0, 0, 1, 0);
    chk("halt_not_yet", bus.halted, 1'b0);
    step(0, 0, 0, 1, 1);
    chk("halt_drain0", bus.bundle_pc, 32'h4);
    step(0, 0, 0, 1, 1);
    chk("halt_drain1", bus.bundle_pc, 32'h14);
    chk("halt_last_pop", bus.halted, 1'b0);
    step(0, 0, 0, 1, 1);
    chk("halted_rise", bus.halted, 1'b1);
    chk("halted_rd_en", bus.imem_rd_en, 1'b0);
    step(1, 0, 0, 0, 0);

    // reset with the queue full
    run(4, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_stall", bus.stall_out, 1'b1);
    chk("rst_rd_en", bus.imem_rd_en, 1'b0);
    step(0, 0, 0, 0, 0);
    chk("rst_valid", bus.bundle_valid, 1'b0);
    chk("rst_halted", bus.halted, 1'b0);

    // randomized traffic
    hstim = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) == 0) || (halt_q_m && ($urandom_range(0, 9) == 0));
      if (!hstim && $urandom_range(0, 149) == 0) hstim = 1'b1;
      sq  = !hstim && ($urandom_range(0, 11) == 0);
      tgt = 32'($urandom_range(0, 4095)) << 4;
      rdy = ($urandom_range(0, 9) < 7);
      h   = hstim;
      step(r, sq, tgt, h, rdy);
      if (r) hstim = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Front-end fetch stage that sits between the program counter and the four decode lanes. Each cycle it takes the current PC value, reads one 4-instruction (128-bit) bundle from instruction memory, and buffers returned bundles in a 2-entry queue toward decode. It drives `stall` back to the program counter when it has no buffer credit. It honours the PC's `squash` and `halt_out` outputs by flushing wrong-path bundles and draining to a clean halt.

## Interface
- `LANES`, default 4: instructions per bundle.
- `INST_W`, default 32: instruction width; bundle width is `LANES*INST_W` = 128.
- `DEPTH`, default 2: bundle queue entries.
- `clk`  in  1: clock.
- `rst`  in  1: synchronous, active-high reset.
- `pc_in`  in  32: PC's `pc` output; bundle address.
- `squash_in`  in  1: PC's `squash`; 1 on the cycle `pc_in` holds a branch target.
- `halt_in`  in  1: PC's `halt_out`.
- `stall_out`  out  1: to PC `stall`; PC must hold `pc_in`.
- `imem_rd_en`  out  1: instruction memory read strobe.
- `imem_addr`  out  32: equals `pc_in`.
- `imem_rdata`  in  128: bundle, valid exactly 1 cycle after `imem_rd_en`.
- `bundle_valid`  out  1: queue head valid.
- `bundle_data`  out  128: lane0 is `[31:0]` at `bundle_pc`; lane3 is `[127:96]` at `bundle_pc`+12.
- `bundle_pc`  out  32: address of lane0.
- `bundle_ready`  in  1: decode accepts the head.
- `halted`  out  1: halt latched, queue empty, and nothing in flight.

## Operation
- **State:**
  - `count` (0..DEPTH).
  - `inflight` (1 bit) plus `inflight_pc`.
  - `halt_q` (sticky).
  - The queue.
- **Pop:**
  - `pop = bundle_valid & bundle_ready & ~squash_in`.
- **Issue:**
  - `issue = ~rst & ~halt_q & ~halt_in & ((count + inflight - pop) < DEPTH)`.
  - `imem_rd_en = issue`.
  - `stall_out = ~issue`, combinational.
  - Stalled PCs are re-presented by the PC and issued later; no address is skipped or duplicated.
- **Response:**
  - `push = inflight & ~squash_in`.
  - On push, `imem_rdata` is written with `inflight_pc`.
  - `inflight` is set to `issue` and `inflight_pc` to `pc_in` on every edge.
- **Squash:**
  - `count` goes to 0; the queue is flushed.
  - The response returning this cycle is dropped.
  - `issue` is still evaluated, with `count` treated as 0, so the target at `pc_in` is fetched in the same cycle.
  - A squash arriving with `stall_out` high frees credit immediately.
- **Count update:**
  - Without squash, `count` becomes `count + push - pop`.
  - Overflow is impossible by credit; an assertion checks `count <= DEPTH`.
- **Halt:**
  - `halt_q` is set on the first edge with `halt_in=1`, cleared only by `rst`.
  - After halt, issue stops, and queued and in-flight bundles still drain to decode.
  - `halted = halt_q & (count==0) & ~inflight`.
- **Reset state:**
  - `count`, `inflight`, and `halt_q` are 0, so `bundle_valid=0` and `halted=0`.
  - While `rst` is high, `imem_rd_en=0` and `stall_out=1`.
  - Reset mid-operation discards all queued and in-flight bundles.

## Timing
- Fetch pipeline:
  - Cycle n: `imem_rd_en` at `pc_in`=A.
  - Cycle n+1: `imem_rdata` valid, pushed at the edge.
  - Cycle n+2: `bundle_valid` with `bundle_pc`=A.
  - Latency from PC to decode is 2 cycles; there is no bypass.
- Throughput with `bundle_ready=1` is one bundle per cycle, with `stall_out=0`.
- Ordering is strictly in PC-issue order.
- Squash at cycle s:
  - The first target bundle appears at s+2.
  - No bundle issued before s is ever presented after s.
- Stall is combinational, same cycle, from registered `count`/`inflight` and the `bundle_ready` pop. There is no path from `imem_rdata` to `stall_out`.
- `halted` rises on the cycle after the last pop when nothing is in flight.

## Structure
- **`vliw_fetch_pkg`:**
  - Constants `LANES`, `INST_W`, `BUNDLE_W`, `PC_STEP`=16, `RESET_PC`=32'h4.
  - `bundle_t` struct: `pc[31:0]`, `data[127:0]`.
- **Sub-module `fetch_fifo`:**
  - Parameterized DEPTH, synchronous, with `push`, `pop`, `flush`, `count`, and head output of `bundle_t`.
- **`inst_fetch_unit`:**
  - Holds the credit, in-flight, squash, and halt logic.

## Test plan
1. **Free run:** after reset, with `bundle_ready=1` and PC stepping 0x4, 0x14, 0x24 → `bundle_pc` shows 0x4 at issue+2, then 0x14 and 0x24 on consecutive cycles; `stall_out` stays 0.
2. **Backpressure:** `bundle_ready=0` from the first valid → after 2 bundles (0x4, 0x14) are queued, `stall_out=1` and there is no `imem_rd_en`. Raise ready → order is 0x4, 0x14, 0x24 with no loss or duplicate.
3. **Squash:** queue holds 0x14 and 0x24 is in flight; `squash_in=1` with `pc_in`=0x100 → 0x14 and 0x24 never reach decode, and the next `bundle_pc` is 0x100, two cycles later.
4. **Squash with pop:** `squash_in`, `bundle_valid`, and `bundle_ready` all high → no pop is counted, the queue is empty next cycle, and the target is issued that cycle.
5. **Halt:** `halt_in=1` with 2 bundles queued and ready=0 → no further `imem_rd_en`. Release ready → 2 bundles drain, and `halted=1` the cycle after the last pop.
6. **Reset mid-op:** `rst` with the queue full → during reset `stall_out=1` and `imem_rd_en=0`; the next cycle has `bundle_valid=0` and `halted=0`.
